// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus state encodings and wait-cycle limit
package bus_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bus_state_t;
    localparam int WAIT_MAX = 7;
endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-port round-robin arbiter onto a single memory bus
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic        we_0,
    input  logic [15:0] address_0,
    input  logic [15:0] wdata_0,
    output logic [15:0] rdata_0,
    output logic        ack_0,
    input  logic        req_1,
    input  logic        we_1,
    input  logic [15:0] address_1,
    input  logic [15:0] wdata_1,
    output logic [15:0] rdata_1,
    output logic        ack_1,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    output logic        mem_bus_enable,
    output logic        mem_write_enable
);
    localparam logic [2:0] WAIT_Q = (WAIT_CYCLES > WAIT_MAX) ? 3'(WAIT_MAX) : 3'(WAIT_CYCLES);

    bus_state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       gnt, gnt_n, last_grant, we_q;
    logic       grant, sel_we, next_final, cur_final;

    assign grant      = (state == IDLE) && (req_0 || req_1);
    assign sel_we     = gnt_n ? we_1 : we_0;
    assign next_final = (state_n == ACCESS) && (cnt_n == WAIT_Q);
    assign cur_final  = (state == ACCESS) && (cnt == WAIT_Q);

    // next state, access counter and grant decision
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        gnt_n   = gnt;
        case (state)
            IDLE: if (req_0 || req_1) begin
                state_n = ACCESS;
                gnt_n   = (req_0 && req_1) ? ~last_grant : req_1;
            end
            ACCESS: begin
                cnt_n   = cnt + 3'd1;
                state_n = (cnt == WAIT_Q) ? DONE : ACCESS;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state register, counter and grant bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            if (grant) begin
                last_grant <= gnt_n;
                we_q       <= sel_we;
            end
        end
    end

    // registered bus, ack and read-data outputs, derived from the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address      <= '0;
            mem_data_in      <= '0;
            mem_bus_enable   <= 1'b0;
            mem_write_enable <= 1'b0;
            ack_0            <= 1'b0;
            ack_1            <= 1'b0;
            rdata_0          <= '0;
            rdata_1          <= '0;
        end else begin
            if (grant) begin
                mem_address <= gnt_n ? address_1 : address_0;
                mem_data_in <= gnt_n ? wdata_1 : wdata_0;
            end
            mem_bus_enable   <= (state_n == ACCESS);
            mem_write_enable <= next_final && (grant ? sel_we : we_q);
            ack_0            <= (state_n == DONE) && !gnt_n;
            ack_1            <= (state_n == DONE) && gnt_n;
            if (cur_final && !we_q && !gnt) rdata_0 <= mem_data_out;
            if (cur_final && !we_q && gnt) rdata_1 <= mem_data_out;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of arbitration, timing, reset and wait-cycle variants
module tb_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_0 = 1'b0, we_0 = 1'b0, req_1 = 1'b0, we_1 = 1'b0;
    logic [15:0] address_0 = '0, wdata_0 = '0, address_1 = '0, wdata_1 = '0;
    logic [15:0] mem [0:65535];
    int checks = 0;
    int failures = 0;

    logic [15:0] rd0_1, rd1_1, ma_1, md_1, mo_1;
    logic        a0_1, a1_1, en_1, wen_1;
    logic [15:0] rd0_0, rd1_0, ma_0, md_0, mo_0;
    logic        a0_0, a1_0, en_0, wen_0;
    logic [15:0] rd0_7, rd1_7, ma_7, md_7, mo_7;
    logic        a0_7, a1_7, en_7, wen_7;

    always #5 clk = ~clk;

    assign mo_1 = mem[ma_1];
    assign mo_0 = mem[ma_0];
    assign mo_7 = mem[ma_7];

    always @(posedge clk) if (en_1 && wen_1) mem[ma_1] <= md_1;

    bus_arbiter #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset),
        .req_0(req_0), .we_0(we_0), .address_0(address_0), .wdata_0(wdata_0), .rdata_0(rd0_1), .ack_0(a0_1),
        .req_1(req_1), .we_1(we_1), .address_1(address_1), .wdata_1(wdata_1), .rdata_1(rd1_1), .ack_1(a1_1),
        .mem_address(ma_1), .mem_data_in(md_1), .mem_data_out(mo_1),
        .mem_bus_enable(en_1), .mem_write_enable(wen_1)
    );
    bus_arbiter #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset),
        .req_0(req_0), .we_0(we_0), .address_0(address_0), .wdata_0(wdata_0), .rdata_0(rd0_0), .ack_0(a0_0),
        .req_1(req_1), .we_1(we_1), .address_1(address_1), .wdata_1(wdata_1), .rdata_1(rd1_0), .ack_1(a1_0),
        .mem_address(ma_0), .mem_data_in(md_0), .mem_data_out(mo_0),
        .mem_bus_enable(en_0), .mem_write_enable(wen_0)
    );
    bus_arbiter #(.WAIT_CYCLES(7)) u7 (
        .clk(clk), .reset(reset),
        .req_0(req_0), .we_0(we_0), .address_0(address_0), .wdata_0(wdata_0), .rdata_0(rd0_7), .ack_0(a0_7),
        .req_1(req_1), .we_1(we_1), .address_1(address_1), .wdata_1(wdata_1), .rdata_1(rd1_7), .ack_1(a1_7),
        .mem_address(ma_7), .mem_data_in(md_7), .mem_data_out(mo_7),
        .mem_bus_enable(en_7), .mem_write_enable(wen_7)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_0 = 1'b0;
        req_1 = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run(input bit p, input logic w, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output int np, output logic [15:0] wa, output logic [15:0] wd);
        bit got;
        got = 1'b0;
        lat = 0;
        np = 0;
        wa = '0;
        wd = '0;
        if (p) begin
            req_1 = 1'b1; we_1 = w; address_1 = a; wdata_1 = d;
        end else begin
            req_0 = 1'b1; we_0 = w; address_0 = a; wdata_0 = d;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            lat++;
            if (wen_1) begin
                np++;
                wa = ma_1;
                wd = md_1;
            end
            got = p ? a1_1 : a0_1;
        end
        if (p) req_1 = 1'b0;
        else req_0 = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int lat, np, n, f0, f7, acks, wes;
        logic [15:0] wa, wd;
        int exp_c[6] = '{3, 7, 11, 15, 19, 23};
        bit exp_p[6] = '{0, 0, 0, 1, 0, 0};
        bit exp_t[4] = '{0, 1, 0, 1};
        mem[16'h0004] = 16'h1234;
        mem[16'h0100] = 16'h0000;
        mem[16'h6010] = 16'h0000;
        do_reset();
        chk("rst_ctl", {28'd0, en_1, wen_1, a0_1, a1_1}, 32'd0);
        chk("rst_addr", 32'(ma_1), 32'd0);
        chk("rst_din", 32'(md_1), 32'd0);
        chk("rst_rdata", {rd0_1, rd1_1}, 32'd0);

        run(1'b0, 1'b0, 16'h0004, 16'h0000, lat, np, wa, wd);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_we", 32'(np), 32'd0);
        chk("rd_rdata0", 32'(rd0_1), 32'h1234);
        chk("rd_rdata1", 32'(rd1_1), 32'd0);
        chk("rd_en_done", 32'(en_1), 32'd0);

        tick();
        run(1'b1, 1'b1, 16'h6010, 16'hBEEF, lat, np, wa, wd);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_pulses", 32'(np), 32'd1);
        chk("wr_addr", 32'(wa), 32'h6010);
        chk("wr_data", 32'(wd), 32'hBEEF);
        chk("wr_mem", 32'(mem[16'h6010]), 32'hBEEF);
        chk("wr_rdata", {rd0_1, rd1_1}, 32'h1234_0000);
        tick();
        run(1'b1, 1'b0, 16'h6010, 16'h0000, lat, np, wa, wd);
        chk("rb_rdata1", 32'(rd1_1), 32'hBEEF);
        chk("rb_rdata0", 32'(rd0_1), 32'h1234);

        do_reset();
        we_0 = 1'b0; we_1 = 1'b0; address_0 = 16'h0004; address_1 = 16'h6010;
        req_0 = 1'b1; req_1 = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            chk("tie_overlap", 32'(a0_1 && a1_1), 32'd0);
            if (a0_1 || a1_1) begin
                chk($sformatf("tie_order%0d", n), 32'(a1_1), 32'(exp_t[n]));
                n++;
            end
            req_0 = !a0_1;
            req_1 = !a1_1;
        end
        chk("tie_count", 32'(n), 32'd4);
        req_0 = 1'b0; req_1 = 1'b0;

        do_reset();
        req_0 = 1'b1;
        n = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk("held_overlap", 32'(a0_1 && a1_1), 32'd0);
            if ((a0_1 || a1_1) && n < 6) begin
                chk($sformatf("held_cyc%0d", n), 32'(c), 32'(exp_c[n]));
                chk($sformatf("held_port%0d", n), 32'(a1_1), 32'(exp_p[n]));
                n++;
            end
            if (c == 10) req_1 = 1'b1;
            if (a1_1) req_1 = 1'b0;
        end
        chk("held_count", 32'(n), 32'd6);
        req_0 = 1'b0; req_1 = 1'b0;

        do_reset();
        req_0 = 1'b1; we_0 = 1'b1; address_0 = 16'h0100; wdata_0 = 16'hAAAA;
        tick();
        chk("mid_en", 32'(en_1), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ctl", {28'd0, en_1, wen_1, a0_1, a1_1}, 32'd0);
        chk("mid_rst_addr", {ma_1, md_1}, 32'd0);
        req_0 = 1'b0;
        tick();
        reset = 1'b0;
        acks = 0;
        wes = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            acks += int'(a0_1) + int'(a1_1);
            wes += int'(wen_1);
        end
        chk("mid_acks", 32'(acks), 32'd0);
        chk("mid_wes", 32'(wes), 32'd0);
        chk("mid_mem", 32'(mem[16'h0100]), 32'd0);
        run(1'b0, 1'b0, 16'h0004, 16'h0000, lat, np, wa, wd);
        chk("mid_rd_lat", 32'(lat), 32'd3);
        chk("mid_rd_data", 32'(rd0_1), 32'h1234);

        do_reset();
        req_0 = 1'b1; we_0 = 1'b0; address_0 = 16'h0004;
        f0 = 0;
        f7 = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (a0_0 && f0 == 0) f0 = c;
            if (a0_7 && f7 == 0) f7 = c;
            if (c == 9) req_0 = 1'b0;
        end
        chk("w0_lat", 32'(f0), 32'd2);
        chk("w7_lat", 32'(f7), 32'd9);
        chk("w0_rdata", 32'(rd0_0), 32'h1234);
        chk("w7_rdata", 32'(rd0_7), 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock, `clk`; reset is asynchronous and active-high, on port `reset`.
REQ-002 The block SHALL have parameter `WAIT_CYCLES`, default 1, meaning extra ACCESS cycles before read capture (allowed range 0..7).
REQ-003 Ports (name, direction, width, meaning):
- `clk`, in, 1, system clock.
- `reset`, in, 1, async active-high reset.
- `req_0`, in, 1, requester 0 (CPU) access request.
- `we_0`, in, 1, requester 0 write select.
- `address_0`, in, 16, requester 0 address.
- `wdata_0`, in, 16, requester 0 write data.
- `rdata_0`, out, 16, requester 0 read data (registered).
- `ack_0`, out, 1, requester 0 completion pulse.
- `req_1`, `we_1`, `address_1`, `wdata_1`, `rdata_1`, `ack_1`: same as port 0, for requester 1 (DMA/loader).
- `mem_address`, out, 16, address to memory bus.
- `mem_data_in`, out, 16, write data to memory bus.
- `mem_data_out`, in, 16, read data from memory bus.
- `mem_bus_enable`, out, 1, bus enable to memory bus.
- `mem_write_enable`, out, 1, write strobe to memory bus.

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and DONE; all outputs SHALL be registered.
REQ-005 In IDLE, if either `req_n` is sampled high, the block SHALL grant one port, latch its address, write data and `we`, and enter ACCESS on the next edge.
REQ-006 Arbitration SHALL be round-robin: the sole requester wins; when both request, the port not granted last wins.
- `last_grant` updates at each grant.
REQ-007 ACCESS SHALL last exactly `WAIT_CYCLES`+1 cycles, counted by an internal 3-bit counter; `mem_bus_enable` SHALL be 1 throughout ACCESS and 0 otherwise.
REQ-008 `mem_address` and `mem_data_in` SHALL hold the latched values for all of ACCESS; requester input changes after the grant SHALL be ignored.
REQ-009 For writes, `mem_write_enable` SHALL be 1 only in the final ACCESS cycle, giving exactly one strobe per transaction.
REQ-010 For reads, `mem_write_enable` SHALL stay 0.
REQ-011 For reads, `mem_data_out` SHALL be captured at the end of the final ACCESS cycle into `rdata_n` of the granted port.
- The other port's `rdata` is unchanged.
- Writes leave both `rdata` registers unchanged.
REQ-012 In DONE, `ack_n` of the granted port SHALL be high for exactly one cycle; the FSM then returns to IDLE.
REQ-013 Latency: if `req` is sampled at the end of cycle T, `ack` SHALL be high in cycle T+2+`WAIT_CYCLES`.
- Minimum issue interval per transaction is 3+`WAIT_CYCLES` cycles.
REQ-014 A `req` still high in the cycle after `ack` SHALL be treated as a new request.
- Requesters drop `req` on `ack` to avoid a repeat transaction.
REQ-015 Dropping `req` during ACCESS SHALL NOT abort the transaction; `ack` SHALL still pulse.
REQ-016 Accesses to any bank, including ROM writes, SHALL complete normally with `ack`; the arbiter does no address decoding.
REQ-017 `ack_0` and `ack_1` SHALL never be high in the same cycle.

Reset
REQ-018 On `reset`, the block SHALL go to IDLE immediately, asynchronously, including mid-ACCESS, and drive:
- `mem_bus_enable`=0, `mem_write_enable`=0, `ack_0`=`ack_1`=0;
- `mem_address`=0, `mem_data_in`=0, `rdata_0`=`rdata_1`=0;
- counter=0, `last_grant`=1, so port 0 wins the first tie.
REQ-019 A transaction interrupted by reset SHALL produce no `ack` and no write strobe after reset deasserts.

Structure
REQ-020 State encodings (IDLE=0, ACCESS=1, DONE=2) and the `WAIT_CYCLES` range limit SHALL live in the shared bus definitions file, for reuse by the CPU and DMA sequencers.
REQ-021 The block SHALL be a single module with no sub-modules.

Verification
REQ-022 The bench SHALL cover these directed scenarios (`WAIT_CYCLES`=1):
- Single read: port 0 reads 0x0004 holding 0x1234 -> `ack_0` 3 cycles after `req`, `rdata_0`=0x1234, `rdata_1` unchanged.
- Single write: port 1 writes 0xBEEF to 0x6010 -> `mem_write_enable` high exactly one cycle with `mem_address`=0x6010 and `mem_data_in`=0xBEEF; readback returns 0xBEEF.
- Tie after reset: both ports request continuously and drop `req` on `ack`; grants follow 0, 1, 0, 1; acks never overlap.
- Held request: `req_0` held high 10 cycles past `ack` -> repeated transactions every 4 cycles; port 1 request interleaves within one slot.
- Reset mid-ACCESS on a write -> no `mem_write_enable` pulse, no `ack`, all outputs 0; a read afterward completes normally.
- `WAIT_CYCLES`=0 and 7 -> `ack` at T+2 and T+9 respectively.
